mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single memory port between the fetch stage (instruction requests) and the execute stage (load/store requests). It sits between the pipeline's imem/dmem interfaces and the external memory bus. It captures requests, grants one transaction at a time, routes each response back to its owner, and drops stale instruction traffic when fetch is flushed.

## Interface
- No parameters; address and data are 32 bits, byte strobe is 4 bits.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_valid  in  1  fetch request pulse (one cycle)
- imem_addr  in  32  fetch address
- imem_flush  in  1  fetch redirect; cancels pending or outstanding fetch
- imem_ready  out  1  fetch response strobe
- imem_rdata  out  32  fetch read data
- dmem_valid  in  1  data request pulse (one cycle)
- dmem_addr  in  32  data address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  store byte strobe; 0 = load
- dmem_ready  out  1  data response strobe
- dmem_rdata  out  32  load data
- mem_valid  out  1  bus request, held until mem_ready
- mem_instr  out  1  1 = instruction transaction
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus store data
- mem_wstrb  out  4  bus byte strobe
- mem_ready  in  1  bus completion strobe
- mem_rdata  in  32  bus read data
- arb_err  out  1  sticky protocol-violation flag

## Operation
- Per-requester pending slot (ipend, dpend) holds the captured address, wdata and wstrb. A valid pulse loads the slot on the same edge.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: if any pending slot is set (including one loading this cycle), grant per policy. Move to BUSY_x, clear that slot, and register the mem_* outputs from it.
- BUSY_x: mem_valid=1 and the mem_* outputs stay stable until mem_ready=1.
- Completion in BUSY_x:
  - Pulse x's ready for that cycle; rdata is mem_rdata passed through combinationally.
  - If another slot is pending, grant it directly (back-to-back, mem_valid stays 1 with new fields next cycle); otherwise go to IDLE.
- Fixed policy: data beats instruction on simultaneous pending.
- imem_flush:
  - Clears ipend.
  - If in BUSY_I, set drop flag: the in-flight completion is consumed without asserting imem_ready. The flag clears on that completion.
  - A new imem_valid in the same cycle as the flush is captured after the clear (it survives).
- Protocol violation: the same requester pulses valid while its slot is pending or its transaction is outstanding and not dropped. The new request is ignored and arb_err is set until reset.
- Reset: state IDLE; slots, drop flag and arb_err cleared; all outputs 0. A reset mid-transaction aborts it with no response.

## Timing
- Request pulse at cycle N with the arbiter idle: mem_valid=1 at N+1.
- Completion: requester ready is asserted in the same cycle as mem_ready (zero added response latency).
- Minimum per-request latency is 1 cycle plus the memory wait.
- Back-to-back: next transaction's mem_valid is 1 in the cycle after the previous mem_ready.
- A request arriving during BUSY waits in its slot; it is issued no earlier than the cycle after the current completion.
- imem_ready and dmem_ready are never both 1 in the same cycle.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. A last-grant bit (reset = instruction) gives the other requester priority on a tie.
- Undefined: fixed data-first priority. Fetch can be delayed only while data requests keep pending.

## Test plan
- Single fetch: imem_valid at cycle 0 with addr 0x100; memory ready at cycle 3 with rdata 0x13 -> mem_valid 1–3, mem_instr=1, imem_ready=1 at cycle 3 with 0x13.
- Simultaneous imem_valid(0x200) and dmem_valid(0x8000, wstrb=0xF), fixed priority -> data issued first. On its mem_ready, the fetch is issued the next cycle with mem_valid held high. The ready strobes are in the correct order.
- Same tie with MEM_ARB_RR_EN -> first tie after reset grants data, second tie grants instruction.
- Flush during BUSY_I: mem_ready arrives 2 cycles later -> imem_ready stays 0. A fetch captured in the flush cycle then issues and completes normally.
- Second dmem_valid while a data transaction is outstanding -> request ignored and arb_err=1 sticky; the first transaction completes normally.
- Assert rst while mem_valid=1 -> all outputs 0 immediately. After release, a fresh fetch completes with 1-cycle issue latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between fetch and execute.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is data-first priority.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        imem_valid,
   input  logic [31:0] imem_addr,
   input  logic        imem_flush,
   output logic        imem_ready,
   output logic [31:0] imem_rdata,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic        dmem_ready,
   output logic [31:0] dmem_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        arb_err
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

   state_t        state;
   logic          ipend, dpend, drop;
   logic [AW-1:0] ipend_addr, dpend_addr;
   logic [DW-1:0] dpend_wdata;
   logic [SW-1:0] dpend_wstrb;
`ifdef MEM_ARB_RR_EN
   logic          last_tie_d;
`endif

   logic          done, i_live, i_viol, d_viol, i_acc, d_acc;
   logic          i_req, d_req, can_grant, pick_d, grant_i, grant_d;
   logic [AW-1:0] i_addr_sel, d_addr_sel;
   logic [DW-1:0] d_wdata_sel;
   logic [SW-1:0] d_wstrb_sel;

   // Request capture, violation detection and grant decision for this cycle.
   always_comb begin
      done        = (state != IDLE) && mem_ready;
      i_live      = (state == BUSY_I) && !drop && !imem_flush;
      i_viol      = imem_valid && ((ipend && !imem_flush) || (i_live && !mem_ready));
      d_viol      = dmem_valid && (dpend || ((state == BUSY_D) && !mem_ready));
      i_acc       = imem_valid && !i_viol;
      d_acc       = dmem_valid && !d_viol;
      i_req       = (ipend && !imem_flush) || i_acc;
      d_req       = dpend || d_acc;
      i_addr_sel  = i_acc ? imem_addr : ipend_addr;
      d_addr_sel  = d_acc ? dmem_addr : dpend_addr;
      d_wdata_sel = d_acc ? dmem_wdata : dpend_wdata;
      d_wstrb_sel = d_acc ? dmem_wstrb : dpend_wstrb;
      can_grant   = (state == IDLE) || done;
`ifdef MEM_ARB_RR_EN
      pick_d      = d_req && !(i_req && last_tie_d);
`else
      pick_d      = d_req;
`endif
      grant_d     = can_grant && pick_d;
      grant_i     = can_grant && i_req && !pick_d;
   end

   // Responses return with zero added latency; a flushed fetch never sees its data.
   assign imem_ready = (state == BUSY_I) && mem_ready && !drop && !imem_flush;
   assign dmem_ready = (state == BUSY_D) && mem_ready;
   assign imem_rdata = imem_ready ? mem_rdata : '0;
   assign dmem_rdata = dmem_ready ? mem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ipend       <= 1'b0;
         dpend       <= 1'b0;
         drop        <= 1'b0;
         ipend_addr  <= '0;
         dpend_addr  <= '0;
         dpend_wdata <= '0;
         dpend_wstrb <= '0;
         arb_err     <= 1'b0;
         mem_valid   <= 1'b0;
         mem_instr   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_wstrb   <= '0;
`ifdef MEM_ARB_RR_EN
         last_tie_d  <= 1'b0;
`endif
      end else begin
         if (i_viol || d_viol) arb_err <= 1'b1;
         if (i_acc) ipend_addr <= imem_addr;
         if (d_acc) begin
            dpend_addr  <= dmem_addr;
            dpend_wdata <= dmem_wdata;
            dpend_wstrb <= dmem_wstrb;
         end
         ipend <= i_req && !grant_i;
         dpend <= d_req && !grant_d;

         if (done)                                drop <= 1'b0;
         else if ((state == BUSY_I) && imem_flush) drop <= 1'b1;

`ifdef MEM_ARB_RR_EN
         // Only contested grants move the fairness pointer.
         if (can_grant && i_req && d_req) last_tie_d <= pick_d;
`endif

         if (grant_d) begin
            state     <= BUSY_D;
            mem_valid <= 1'b1;
            mem_instr <= 1'b0;
            mem_addr  <= d_addr_sel;
            mem_wdata <= d_wdata_sel;
            mem_wstrb <= d_wstrb_sel;
         end else if (grant_i) begin
            state     <= BUSY_I;
            mem_valid <= 1'b1;
            mem_instr <= 1'b1;
            mem_addr  <= i_addr_sel;
            mem_wdata <= '0;
            mem_wstrb <= '0;
         end else if (done) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then randomized traffic checked by a scoreboard.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_valid, imem_flush, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        dmem_valid, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        mem_valid, mem_instr, mem_ready, arb_err;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_flush(imem_flush),
      .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .arb_err(arb_err)
   );

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      bit          want_ready;
   } fent_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } dent_t;

   fent_t fq[$];
   dent_t dq[$];
   int    tests = 0;
   int    fails = 0;
   bit    rand_mode = 1'b0;

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_valid = 1'b0; imem_addr = '0; imem_flush = 1'b0;
      dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
      mem_ready = 1'b0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
   endtask

   // One random cycle: memory model, optional flush, new requests obeying the protocol.
   task automatic drive_random(input bit gen);
      fent_t nq[$];
      bit    f_live;
      mem_ready  = mem_valid && ($urandom_range(0, 2) == 0);
      mem_rdata  = mem_ready ? hash(mem_addr) : $urandom;
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      imem_flush = gen && ($urandom_range(0, 15) == 0);
      if (imem_flush) begin
         // Only a fetch already on the bus survives the flush, and it gets no response.
         nq = {};
         foreach (fq[i])
            if (i == 0 && mem_valid && mem_instr) nq.push_back('{fq[i].addr, 1'b0});
         fq = nq;
      end
      f_live = 1'b0;
      foreach (fq[i]) if (fq[i].want_ready) f_live = 1'b1;
      if (gen && !f_live && $urandom_range(0, 2) == 0) begin
         imem_valid = 1'b1;
         imem_addr  = $urandom & 32'hFFFF_FFFC;
         fq.push_back('{imem_addr, 1'b1});
      end
      if (gen && dq.size() == 0 && $urandom_range(0, 2) == 0) begin
         dmem_valid = 1'b1;
         dmem_addr  = $urandom & 32'hFFFF_FFFC;
         dmem_wdata = $urandom;
         dmem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         dq.push_back('{dmem_addr, dmem_wdata, dmem_wstrb});
      end
   endtask

   // Scoreboard monitor: pops expectations when the bus completes a transaction.
   initial begin : monitor
      bit          prev_wait;
      logic [31:0] s_addr, s_wdata;
      logic [3:0]  s_wstrb;
      logic        s_instr;
      fent_t       fe;
      dent_t       de;
      prev_wait = 1'b0;
      forever begin
         @(negedge clk);
         if (!rand_mode) begin
            prev_wait = 1'b0;
         end else begin
            chk("ready_exclusive", 32'(imem_ready && dmem_ready), 32'd0);
            if (prev_wait) begin
               chk("hold_addr", mem_addr, s_addr);
               chk("hold_instr", 32'(mem_instr), 32'(s_instr));
               chk("hold_wdata", mem_wdata, s_wdata);
               chk("hold_wstrb", 32'(mem_wstrb), 32'(s_wstrb));
            end
            if (mem_valid && mem_ready && mem_instr) begin
               if (fq.size() == 0) begin
                  chk("unexpected_fetch", 32'd1, 32'd0);
               end else begin
                  fe = fq.pop_front();
                  chk("fetch_addr", mem_addr, fe.addr);
                  chk("imem_ready", 32'(imem_ready), 32'(fe.want_ready));
                  if (fe.want_ready) chk("imem_rdata", imem_rdata, hash(fe.addr));
               end
            end else if (mem_valid && mem_ready) begin
               if (dq.size() == 0) begin
                  chk("unexpected_data", 32'd1, 32'd0);
               end else begin
                  de = dq.pop_front();
                  chk("data_addr", mem_addr, de.addr);
                  chk("data_wdata", mem_wdata, de.wdata);
                  chk("data_wstrb", 32'(mem_wstrb), 32'(de.wstrb));
                  chk("dmem_ready", 32'(dmem_ready), 32'd1);
                  chk("dmem_rdata", dmem_rdata, hash(de.addr));
               end
            end else begin
               chk("no_resp_imem", 32'(imem_ready), 32'd0);
               chk("no_resp_dmem", 32'(dmem_ready), 32'd0);
            end
            prev_wait = mem_valid && !mem_ready;
            s_addr = mem_addr; s_instr = mem_instr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
         end
      end
   end

   initial begin : main
      idle_inputs();
      rst = 1'b1;
      #3;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_arb_err", 32'(arb_err), 32'd0);
      chk("rst_imem_ready", 32'(imem_ready), 32'd0);
      do_reset();

      // Single fetch with two wait cycles.
      imem_valid = 1'b1; imem_addr = 32'h100;
      cyc(); imem_valid = 1'b0;
      chk("f1_valid", 32'(mem_valid), 32'd1);
      chk("f1_instr", 32'(mem_instr), 32'd1);
      chk("f1_addr", mem_addr, 32'h100);
      cyc();
      chk("f1_wait", 32'(mem_valid), 32'd1);
      chk("f1_no_ready", 32'(imem_ready), 32'd0);
      cyc(); mem_ready = 1'b1; mem_rdata = 32'h13; #1;
      chk("f1_ready", 32'(imem_ready), 32'd1);
      chk("f1_rdata", imem_rdata, 32'h13);
      chk("f1_dready", 32'(dmem_ready), 32'd0);
      cyc(); mem_ready = 1'b0;
      chk("f1_idle", 32'(mem_valid), 32'd0);

      // First tie after reset: data wins in both policies.
      do_reset();
      imem_valid = 1'b1; imem_addr = 32'h200;
      dmem_valid = 1'b1; dmem_addr = 32'h8000; dmem_wdata = 32'hCAFE_F00D; dmem_wstrb = 4'hF;
      cyc(); imem_valid = 1'b0; dmem_valid = 1'b0;
      chk("t1_instr", 32'(mem_instr), 32'd0);
      chk("t1_addr", mem_addr, 32'h8000);
      chk("t1_wstrb", 32'(mem_wstrb), 32'hF);
      chk("t1_wdata", mem_wdata, 32'hCAFE_F00D);
      mem_ready = 1'b1; mem_rdata = 32'hAA; #1;
      chk("t1_dready", 32'(dmem_ready), 32'd1);
      chk("t1_iready", 32'(imem_ready), 32'd0);
      cyc(); mem_ready = 1'b0; #1;
      chk("t1_b2b_valid", 32'(mem_valid), 32'd1);
      chk("t1_b2b_instr", 32'(mem_instr), 32'd1);
      chk("t1_b2b_addr", mem_addr, 32'h200);
      mem_ready = 1'b1; mem_rdata = 32'hBB; #1;
      chk("t1_iready2", 32'(imem_ready), 32'd1);
      chk("t1_irdata", imem_rdata, 32'hBB);
      chk("t1_dready2", 32'(dmem_ready), 32'd0);
      cyc(); mem_ready = 1'b0;
      chk("t1_idle", 32'(mem_valid), 32'd0);

      // Second tie: round-robin now favours fetch, fixed priority still favours data.
      imem_valid = 1'b1; imem_addr = 32'h240;
      dmem_valid = 1'b1; dmem_addr = 32'h8040; dmem_wdata = '0; dmem_wstrb = 4'h0;
      cyc(); imem_valid = 1'b0; dmem_valid = 1'b0;
      chk("t2_first_instr", 32'(mem_instr), 32'(RR));
      chk("t2_first_addr", mem_addr, RR ? 32'h240 : 32'h8040);
      mem_ready = 1'b1; mem_rdata = 32'h11; #1;
      chk("t2_first_iready", 32'(imem_ready), 32'(RR));
      chk("t2_first_dready", 32'(dmem_ready), 32'(!RR));
      cyc(); #1;
      chk("t2_second_instr", 32'(mem_instr), 32'(!RR));
      chk("t2_second_iready", 32'(imem_ready), 32'(!RR));
      chk("t2_second_dready", 32'(dmem_ready), 32'(RR));
      cyc(); mem_ready = 1'b0;
      chk("t2_idle", 32'(mem_valid), 32'd0);

      // Flush during an outstanding fetch, with a new fetch captured in the flush cycle.
      imem_valid = 1'b1; imem_addr = 32'h300;
      cyc(); imem_addr = 32'h400; imem_flush = 1'b1;
      chk("fl_busy", 32'(mem_addr), 32'h300);
      cyc(); imem_valid = 1'b0; imem_flush = 1'b0;
      chk("fl_hold", mem_addr, 32'h300);
      cyc(); mem_ready = 1'b1; mem_rdata = 32'h77; #1;
      chk("fl_dropped", 32'(imem_ready), 32'd0);
      cyc(); mem_ready = 1'b0; #1;
      chk("fl_next_valid", 32'(mem_valid), 32'd1);
      chk("fl_next_addr", mem_addr, 32'h400);
      mem_ready = 1'b1; mem_rdata = 32'h55; #1;
      chk("fl_next_ready", 32'(imem_ready), 32'd1);
      chk("fl_next_rdata", imem_rdata, 32'h55);
      cyc(); mem_ready = 1'b0;
      chk("fl_idle", 32'(mem_valid), 32'd0);
      chk("fl_no_err", 32'(arb_err), 32'd0);

      // Second data request while the first is outstanding.
      dmem_valid = 1'b1; dmem_addr = 32'h10; dmem_wstrb = 4'h0;
      cyc(); dmem_valid = 1'b0;
      cyc(); dmem_valid = 1'b1; dmem_addr = 32'h20;
      cyc(); dmem_valid = 1'b0;
      chk("pv_err", 32'(arb_err), 32'd1);
      chk("pv_addr", mem_addr, 32'h10);
      mem_ready = 1'b1; mem_rdata = 32'h99; #1;
      chk("pv_dready", 32'(dmem_ready), 32'd1);
      chk("pv_drdata", dmem_rdata, 32'h99);
      cyc(); mem_ready = 1'b0;
      chk("pv_ignored", 32'(mem_valid), 32'd0);
      cyc();
      chk("pv_sticky", 32'(arb_err), 32'd1);

      // Reset in the middle of a fetch.
      imem_valid = 1'b1; imem_addr = 32'h600;
      cyc(); imem_valid = 1'b0;
      chk("rm_busy", 32'(mem_valid), 32'd1);
      #2; rst = 1'b1; mem_ready = 1'b1; #1;
      chk("rm_valid", 32'(mem_valid), 32'd0);
      chk("rm_addr", mem_addr, 32'd0);
      chk("rm_instr", 32'(mem_instr), 32'd0);
      chk("rm_iready", 32'(imem_ready), 32'd0);
      chk("rm_err", 32'(arb_err), 32'd0);
      cyc(); rst = 1'b0; mem_ready = 1'b0;
      cyc(); imem_valid = 1'b1; imem_addr = 32'h500;
      cyc(); imem_valid = 1'b0;
      chk("rm_fresh_valid", 32'(mem_valid), 32'd1);
      chk("rm_fresh_addr", mem_addr, 32'h500);
      mem_ready = 1'b1; mem_rdata = 32'h5A; #1;
      chk("rm_fresh_ready", 32'(imem_ready), 32'd1);
      chk("rm_fresh_rdata", imem_rdata, 32'h5A);
      cyc(); mem_ready = 1'b0;

      // Randomized traffic against the scoreboard.
      do_reset();
      rand_mode = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         cyc();
         drive_random(1'b1);
      end
      for (int c = 0; c < 300 && (fq.size() != 0 || dq.size() != 0); c++) begin
         cyc();
         drive_random(1'b0);
      end
      cyc();
      idle_inputs();
      chk("drain_fetch", 32'(fq.size()), 32'd0);
      chk("drain_data", 32'(dq.size()), 32'd0);
      chk("rand_no_err", 32'(arb_err), 32'd0);
      rand_mode = 1'b0;
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
